// File: rtl/text_ram_arbiter.sv
// Arbitrates one single-port text RAM between display fetches, a screen-clear
// sequencer and host writes, with fixed priority display > clear > host.
module text_ram_arbiter #(
  parameter int                ADDR_W     = 12,
  parameter int                DATA_W     = 8,
  parameter int                CELLS      = 2400,
  parameter logic [DATA_W-1:0] CLEAR_CHAR = 8'h20
) (
  input  logic              i_clk_50mhz,
  input  logic              i_reset,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic [DATA_W-1:0] o_disp_data,
  output logic              o_disp_valid,
  input  logic              i_host_valid,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_data,
  output logic              o_host_ready,
  input  logic              i_clear_start,
  output logic              o_clear_busy,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_ram_we,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  // Extra bit so the range check still works when CELLS == 2**ADDR_W.
  localparam logic [ADDR_W:0]   CELLS_X   = (ADDR_W+1)'(CELLS);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                vld_p0_q, vld_p0_d;
  logic                vld_p1_q, vld_p1_d;
  logic [DATA_W-1:0]   disp_data_p1_q, disp_data_p1_d;
  logic                clear_wr;
  logic                host_fire;
  logic                host_in_range;

  always_ff @(posedge i_clk_50mhz or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_clear_start) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        // A display fetch owns the port, so the clear simply stalls.
        if (!i_disp_req) begin
          if (cnt_q == LAST_CELL) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == S_CLEAR);
  end

  always_comb begin
    clear_wr      = (state_q == S_CLEAR) && !i_disp_req;
    o_host_ready  = (state_q == S_IDLE) && !i_disp_req && !i_clear_start;
    host_fire     = i_host_valid && o_host_ready;
    host_in_range = ({1'b0, i_host_addr} < CELLS_X);
    o_ram_addr    = '0;
    o_ram_wdata   = '0;
    o_ram_we      = 1'b0;
    if (i_disp_req) begin
      o_ram_addr = i_disp_addr;
    end else if (clear_wr) begin
      o_ram_addr  = cnt_q;
      o_ram_wdata = CLEAR_CHAR;
      o_ram_we    = 1'b1;
    end else if (host_fire) begin
      // Out-of-range writes complete the handshake but never reach the RAM.
      o_ram_addr  = i_host_addr;
      o_ram_wdata = i_host_data;
      o_ram_we    = host_in_range;
    end
    o_clear_busy = busy_q;
  end

  // Stage p0: RAM is reading the address granted last cycle.
  // Stage p1: capture the RAM output and present it with its valid.
  always_comb begin
    vld_p0_d       = i_disp_req;
    vld_p1_d       = vld_p0_q;
    disp_data_p1_d = vld_p0_q ? i_ram_rdata : disp_data_p1_q;
  end

  always_ff @(posedge i_clk_50mhz or posedge i_reset) begin
    if (i_reset) begin
      vld_p0_q       <= 1'b0;
      vld_p1_q       <= 1'b0;
      disp_data_p1_q <= '0;
    end else begin
      vld_p0_q       <= vld_p0_d;
      vld_p1_q       <= vld_p1_d;
      disp_data_p1_q <= disp_data_p1_d;
    end
  end

  assign o_disp_valid = vld_p1_q;
  assign o_disp_data  = disp_data_p1_q;

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Scoreboard bench for text_ram_arbiter with a registered-read RAM model.
module tb_text_ram_arbiter;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int CELLS  = 2400;

  logic              clk = 1'b0;
  logic              rst;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              host_valid;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_data;
  logic              host_ready;
  logic              clear_start;
  logic              clear_busy;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  logic [DATA_W-1:0] mem [0:4095];
  logic              bd_fill;
  logic              bd_we;
  logic [ADDR_W-1:0] bd_addr;
  logic [DATA_W-1:0] bd_data;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  text_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CELLS(CELLS), .CLEAR_CHAR(8'h20)) dut (
    .i_clk_50mhz  (clk),
    .i_reset      (rst),
    .i_disp_req   (disp_req),
    .i_disp_addr  (disp_addr),
    .o_disp_data  (disp_data),
    .o_disp_valid (disp_valid),
    .i_host_valid (host_valid),
    .i_host_addr  (host_addr),
    .i_host_data  (host_data),
    .o_host_ready (host_ready),
    .i_clear_start(clear_start),
    .o_clear_busy (clear_busy),
    .o_ram_addr   (ram_addr),
    .o_ram_wdata  (ram_wdata),
    .o_ram_we     (ram_we),
    .i_ram_rdata  (ram_rdata)
  );

  // Text RAM with a backdoor used only while the DUT leaves the port idle.
  always @(posedge clk) begin
    if (bd_fill) begin
      for (int i = 0; i < 4096; i++) mem[i] <= bd_data;
    end else if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every display valid pops the oldest expected fetch.
  always @(negedge clk) begin
    exp_t e;
    if (disp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL disp_unexpected: got data %0h with no fetch outstanding", disp_data);
      end else begin
        e = exp_q.pop_front();
        chk("disp_data", 32'(disp_data), 32'(e.data));
        chk("disp_latency", 32'(cyc), 32'(e.cyc + 2));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int addr, input logic [DATA_W-1:0] expd);
    disp_req  = 1'b1;
    disp_addr = ADDR_W'(addr);
    exp_q.push_back('{expd, cyc});
  endtask

  task automatic bd_write(input int addr, input logic [DATA_W-1:0] data);
    bd_we   = 1'b1;
    bd_addr = ADDR_W'(addr);
    bd_data = data;
    tick();
    bd_we = 1'b0;
  endtask

  // Known background: zeros, 'A'..'C' at 5..7, 8'h77 just past the screen,
  // and a 16-entry pattern at 3000 for fetches that must not see the clear.
  task automatic preload();
    bd_fill = 1'b1;
    bd_data = 8'h00;
    tick();
    bd_fill = 1'b0;
    bd_write(5, 8'h41);
    bd_write(6, 8'h42);
    bd_write(7, 8'h43);
    bd_write(2400, 8'h77);
    for (int k = 0; k < 16; k++) bd_write(3000 + k, 8'(8'h60 + k));
  endtask

  function automatic int count_not_clear();
    int bad = 0;
    for (int i = 0; i < CELLS; i++) if (mem[i] !== 8'h20) bad++;
    return bad;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, %0d checks so far", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int bad;
    rst = 1'b1; disp_req = 1'b0; disp_addr = '0; host_valid = 1'b0; host_addr = '0;
    host_data = '0; clear_start = 1'b0; bd_fill = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    repeat (3) tick();
    chk("rst_disp_valid", 32'(disp_valid), 0);
    chk("rst_disp_data", 32'(disp_data), 0);
    chk("rst_clear_busy", 32'(clear_busy), 0);
    chk("rst_host_ready", 32'(host_ready), 1);
    chk("idle_ram_we", 32'(ram_we), 0);
    chk("idle_ram_addr", 32'(ram_addr), 0);
    preload();
    rst = 1'b0;
    tick();

    // Back-to-back fetches of 5,6,7.
    for (int k = 0; k < 3; k++) begin
      fetch(5 + k, 8'(8'h41 + k));
      #1;
      chk("disp_ram_addr", 32'(ram_addr), 32'(5 + k));
      chk("disp_ram_we", 32'(ram_we), 0);
      tick();
    end
    disp_req = 1'b0;
    repeat (4) tick();

    // Host write blocked by a fetch, then completes next cycle.
    fetch(5, 8'h41);
    host_valid = 1'b1; host_addr = 12'd10; host_data = 8'h41;
    #1;
    chk("host_blocked_ready", 32'(host_ready), 0);
    chk("host_blocked_we", 32'(ram_we), 0);
    tick();
    disp_req = 1'b0;
    #1;
    chk("host_ready", 32'(host_ready), 1);
    chk("host_we", 32'(ram_we), 1);
    chk("host_addr", 32'(ram_addr), 10);
    tick();
    host_valid = 1'b0;
    chk("host_mem10", 32'(mem[10]), 32'h41);

    // Out-of-range host write is accepted and dropped.
    host_valid = 1'b1; host_addr = 12'd2400; host_data = 8'h55;
    #1;
    chk("oor_ready", 32'(host_ready), 1);
    chk("oor_we", 32'(ram_we), 0);
    tick();
    host_valid = 1'b0;
    chk("oor_mem2400", 32'(mem[2400]), 32'h77);
    repeat (3) tick();

    // Clear without display traffic; a second start mid-clear is ignored.
    clear_start = 1'b1;
    #1;
    chk("start_host_ready", 32'(host_ready), 0);
    tick();
    clear_start = 1'b0;
    n = 0; bad = 0;
    while (clear_busy && n < 3000) begin
      clear_start = (n == 100);
      host_valid  = 1'b1; host_addr = 12'd11; host_data = 8'h99;
      #1;
      if (host_ready !== 1'b0) bad++;
      n++;
      tick();
    end
    clear_start = 1'b0; host_valid = 1'b0;
    chk("clear_busy_cycles", 32'(n), CELLS);
    chk("clear_host_ready_low", 32'(bad), 0);
    chk("clear_cells", 32'(count_not_clear()), 0);
    chk("clear_no_overrun", 32'(mem[2400]), 32'h77);
    chk("clear_done_ready", 32'(host_ready), 1);

    // Clear with a fetch every other cycle.
    preload();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    n = 0; bad = 0;
    while (clear_busy && n < 6000) begin
      if (n % 2 == 1) fetch(3000 + (n / 2) % 16, 8'(8'h60 + (n / 2) % 16));
      else disp_req = 1'b0;
      #1;
      if (ram_we !== (n % 2 == 0)) bad++;
      n++;
      tick();
    end
    disp_req = 1'b0;
    chk("shared_clear_cycles", 32'(n), 2 * CELLS - 1);
    chk("shared_clear_we_pattern", 32'(bad), 0);
    chk("shared_clear_cells", 32'(count_not_clear()), 0);
    chk("shared_no_overrun", 32'(mem[2400]), 32'h77);
    repeat (4) tick();

    // Reset aborts a clear at counter 1000.
    preload();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    n = 0;
    while (clear_busy && n < 1000) begin
      n++;
      tick();
    end
    chk("abort_busy_before", 32'(clear_busy), 1);
    rst = 1'b1;
    #1;
    chk("abort_busy_now", 32'(clear_busy), 0);
    chk("abort_we_now", 32'(ram_we), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("abort_cell0", 32'(mem[0]), 32'h20);
    chk("abort_cell999", 32'(mem[999]), 32'h20);
    chk("abort_cell1000", 32'(mem[1000]), 32'h00);
    chk("abort_idle_ready", 32'(host_ready), 1);
    chk("abort_busy_after", 32'(clear_busy), 0);

    fetch(3005, 8'h65);
    tick();
    disp_req = 1'b0;
    repeat (4) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
